// File: rtl/io_uart_bridge_pkg.sv
// Register map and status layout for the IO-space UART bridge.
// Address constants mirror the generated register-map packages.
package top_regs_Consts;
  localparam logic [11:0] ADDR_TOP_UART = 12'h100;
endpackage

package uart_Consts;
  localparam logic [11:0] ADDR_UART_DATA   = 12'h000;
  localparam logic [11:0] ADDR_UART_STATUS = 12'h004;
  localparam int STATUS_TX_FULL    = 0;
  localparam int STATUS_RX_AVAIL   = 1;
  localparam int STATUS_RX_OVERRUN = 2;
  localparam int STATUS_TX_EMPTY   = 3;
endpackage

package io_uart_bridge_pkg;
  // Packed MSB-first so bit positions match the STATUS_* indices.
  typedef struct packed {
    logic tx_empty;
    logic rx_overrun;
    logic rx_avail;
    logic tx_full;
  } status_t;
endpackage

// File: rtl/io_uart_bridge_if.sv
// Push/pop port bundle between the bridge and its byte FIFOs.
interface io_uart_bridge_if #(
  parameter int WIDTH = 8
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] head;
  logic             full;
  logic             empty;

  modport master (
    output push, pop, wdata,
    input  head, full, empty
  );

  modport slave (
    input  push, pop, wdata,
    output head, full, empty
  );
endinterface

// File: rtl/io_uart_bridge_fifo.sv
// Synchronous FIFO with DEPTH_LOG2+1 bit wrapping pointers.
module Sync_Fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input logic        clk_i,
  input logic        rst_ni,
  io_uart_bridge_if.slave f
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign f.empty = (wr_ptr == rd_ptr);
  assign f.full  =
    (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign f.head  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // A pop frees the slot this same edge, so push is allowed when full.
  assign do_pop  = f.pop && !f.empty;
  assign do_push = f.push && (!f.full || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= f.wdata;
  end
endmodule

// File: rtl/io_uart_bridge.sv
// Memory-mapped UART bridge: DATA/STATUS registers over TX and RX
// byte FIFOs feeding AXI-stream style uart ports.
module io_uart_bridge
  import io_uart_bridge_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [11:0] BASE = top_regs_Consts::ADDR_TOP_UART
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        io_read_valid_i,
  input  logic        io_write_valid_i,
  input  logic [11:0] io_addr_i,
  input  logic [31:0] io_wdata_i,
  output logic [31:0] io_rdata_o,
  output logic [7:0]  tx_tdata_o,
  output logic        tx_tvalid_o,
  input  logic        tx_tready_i,
  input  logic [7:0]  rx_tdata_i,
  input  logic        rx_tvalid_i,
  output logic        rx_tready_o
);
  localparam logic [11:0] ADDR_DATA =
    BASE + uart_Consts::ADDR_UART_DATA;
  localparam logic [11:0] ADDR_STATUS =
    BASE + uart_Consts::ADDR_UART_STATUS;

  io_uart_bridge_if #(.WIDTH(8)) tx_q ();
  io_uart_bridge_if #(.WIDTH(8)) rx_q ();

  logic        hit_data;
  logic        hit_status;
  logic        overrun;
  logic        ovr_set;
  logic        ovr_clr;
  logic [31:0] rdata_d;
  status_t     st;
  logic [23:0] unused_wdata;

  assign hit_data   = (io_addr_i == ADDR_DATA);
  assign hit_status = (io_addr_i == ADDR_STATUS);
  assign unused_wdata = io_wdata_i[31:8];

  assign tx_q.push  = io_write_valid_i && hit_data;
  assign tx_q.wdata = io_wdata_i[7:0];
  assign tx_q.pop   = tx_tvalid_o && tx_tready_i;
  assign tx_tvalid_o = !tx_q.empty;
  assign tx_tdata_o  = tx_q.head;

  assign rx_tready_o = rst_ni;
  assign rx_q.push  = rx_tvalid_i && rx_tready_o;
  assign rx_q.wdata = rx_tdata_i;
  assign rx_q.pop   = io_read_valid_i && hit_data && !rx_q.empty;

  // A full FIFO being read this cycle still accepts the byte.
  assign ovr_set = rx_q.push && rx_q.full && !rx_q.pop;
  assign ovr_clr = io_write_valid_i && hit_status && io_wdata_i[2];

  assign st = '{
    tx_empty:   tx_q.empty,
    rx_overrun: overrun,
    rx_avail:   !rx_q.empty,
    tx_full:    tx_q.full
  };

  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      hit_data:
        if (!rx_q.empty) rdata_d = {23'h0, 1'b1, rx_q.head};
      hit_status:
        rdata_d = {28'h0, st};
      default:
        rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun    <= 1'b0;
      io_rdata_o <= '0;
    end else begin
      io_rdata_o <= rdata_d;
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  Sync_Fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .f      (tx_q)
  );

  Sync_Fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .f      (rx_q)
  );
endmodule

// File: tb/tb_io_uart_bridge.sv
// Directed bench for io_uart_bridge: register access, both FIFO
// boundaries, overrun handling and asynchronous reset.
module tb_io_uart_bridge;
  localparam logic [11:0] A_DATA = 12'h100;
  localparam logic [11:0] A_STAT = 12'h104;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        io_read_valid_i = 1'b0;
  logic        io_write_valid_i = 1'b0;
  logic [11:0] io_addr_i = '0;
  logic [31:0] io_wdata_i = '0;
  logic [31:0] io_rdata_o;
  logic [7:0]  tx_tdata_o;
  logic        tx_tvalid_o;
  logic        tx_tready_i = 1'b0;
  logic [7:0]  rx_tdata_i = '0;
  logic        rx_tvalid_i = 1'b0;
  logic        rx_tready_o;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  io_uart_bridge dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .io_read_valid_i  (io_read_valid_i),
    .io_write_valid_i (io_write_valid_i),
    .io_addr_i        (io_addr_i),
    .io_wdata_i       (io_wdata_i),
    .io_rdata_o       (io_rdata_o),
    .tx_tdata_o       (tx_tdata_o),
    .tx_tvalid_o      (tx_tvalid_o),
    .tx_tready_i      (tx_tready_i),
    .rx_tdata_i       (rx_tdata_i),
    .rx_tvalid_i      (rx_tvalid_i),
    .rx_tready_o      (rx_tready_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [11:0] a,
                          input logic [31:0] d);
    io_addr_i = a;
    io_wdata_i = d;
    io_write_valid_i = 1'b1;
    tick();
    io_write_valid_i = 1'b0;
    io_addr_i = '0;
  endtask

  task automatic io_read(input logic [11:0] a,
                         output logic [31:0] d);
    io_addr_i = a;
    io_read_valid_i = 1'b1;
    tick();
    d = io_rdata_o;
    io_read_valid_i = 1'b0;
    io_addr_i = '0;
  endtask

  initial begin
    #1;
    check("rst_tvalid", {31'h0, tx_tvalid_o}, 32'h0);
    check("rst_tready", {31'h0, rx_tready_o}, 32'h0);
    check("rst_rdata", io_rdata_o, 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("ready_out", {31'h0, rx_tready_o}, 32'h1);
    io_read(A_STAT, rd);
    check("stat_idle", rd, 32'h8);

    // two bytes straight through
    tx_tready_i = 1'b1;
    io_write(A_DATA, 32'h41);
    check("tx41_valid", {31'h0, tx_tvalid_o}, 32'h1);
    check("tx41_data", {24'h0, tx_tdata_o}, 32'h41);
    io_write(A_DATA, 32'hFFFF_FF42);
    check("tx42_data", {24'h0, tx_tdata_o}, 32'h42);
    tick();
    check("tx_drained", {31'h0, tx_tvalid_o}, 32'h0);
    io_read(A_STAT, rd);
    check("stat_txempty", rd, 32'h8);

    // unmapped address
    io_write(12'h7FC, 32'h55);
    check("unmapped_nopush", {31'h0, tx_tvalid_o}, 32'h0);
    io_read(12'h7FC, rd);
    check("unmapped_rd", rd, 32'h0);

    // fill TX to 16, 17th dropped
    tx_tready_i = 1'b0;
    for (int i = 0; i < 16; i++) io_write(A_DATA, i);
    io_read(A_STAT, rd);
    check("tx_full", rd, 32'h1);
    io_write(A_DATA, 32'h10);
    io_read(A_STAT, rd);
    check("tx_full_drop", rd, 32'h1);
    tx_tready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("tx_drain_v", {31'h0, tx_tvalid_o}, 32'h1);
      check("tx_drain_d", {24'h0, tx_tdata_o}, i);
      tick();
    end
    check("tx_drain_end", {31'h0, tx_tvalid_o}, 32'h0);

    // single RX byte
    rx_tdata_i = 8'h55;
    rx_tvalid_i = 1'b1;
    tick();
    rx_tvalid_i = 1'b0;
    io_read(A_STAT, rd);
    check("rx_avail", rd, 32'hA);
    io_read(A_DATA, rd);
    check("rx_data55", rd, 32'h155);
    io_read(A_STAT, rd);
    check("rx_empty", rd, 32'h8);
    io_read(A_DATA, rd);
    check("rx_rd_empty", rd, 32'h0);

    // RX overrun: 17 bytes 0x80..0x90
    rx_tvalid_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rx_tdata_i = 8'h80 + 8'(i);
      tick();
    end
    rx_tvalid_i = 1'b0;
    io_read(A_STAT, rd);
    check("ovr_set", rd, 32'hE);
    io_write(A_STAT, 32'h4);
    io_read(A_STAT, rd);
    check("ovr_clr", rd, 32'hA);

    // full FIFO: push and DATA read in one cycle
    rx_tdata_i = 8'hAA;
    rx_tvalid_i = 1'b1;
    io_read(A_DATA, rd);
    rx_tvalid_i = 1'b0;
    check("full_pushpop", rd, 32'h180);
    io_read(A_STAT, rd);
    check("full_no_ovr", rd, 32'hA);
    for (int i = 1; i < 16; i++) begin
      io_read(A_DATA, rd);
      check("rx_drain", rd, 32'h180 + i);
    end
    io_read(A_DATA, rd);
    check("rx_drain_aa", rd, 32'h1AA);
    io_read(A_DATA, rd);
    check("rx_drain_end", rd, 32'h0);

    // overrun set wins over same-cycle clear
    rx_tvalid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_tdata_i = 8'(i);
      tick();
    end
    io_write(A_STAT, 32'h4);
    rx_tvalid_i = 1'b0;
    io_read(A_STAT, rd);
    check("ovr_set_wins", rd, 32'hE);

    // async reset mid-TX
    tx_tready_i = 1'b0;
    for (int i = 0; i < 5; i++) io_write(A_DATA, 32'h60 + i);
    io_read(A_STAT, rd);
    check("pre_rst_stat", rd, 32'h6);
    check("pre_rst_valid", {31'h0, tx_tvalid_o}, 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_tvalid", {31'h0, tx_tvalid_o}, 32'h0);
    check("async_tready", {31'h0, rx_tready_o}, 32'h0);
    check("async_rdata", io_rdata_o, 32'h0);
    tick();
    rst_ni = 1'b1;
    check("post_rst_rdata", io_rdata_o, 32'h0);
    tx_tready_i = 1'b1;
    io_read(A_STAT, rd);
    check("post_rst_stat", rd, 32'h8);
    check("post_rst_valid", {31'h0, tx_tvalid_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
